// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit and its neighbours
// (register file, write-back mux).
package mul_div_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 5;

  localparam logic OP_MULU = 1'b0;
  localparam logic OP_DIVU = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// The accumulator is {hi_half, lo_half}; purely combinational.
module mul_div_step
  import mul_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;

  always_comb begin
    acc_next = acc;
    q_bit    = 1'b0;

    // MULU: add multiplicand into the high half when the current multiplier bit
    // is set, then shift the whole accumulator right, keeping the carry.
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);

    // DIVU: partial remainder shifted left with the next dividend bit (MSB first).
    // A successful subtract always fits in WIDTH bits, so the low bits suffice.
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - operand;

    if (op == OP_MULU) begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end else begin
      q_bit = (div_shift >= {1'b0, operand});
      // Quotient bit is left as zero here; the caller inserts q_bit.
      acc_next = {(q_bit ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: WIDTH cycles per operation,
// HI/LO result registers held between completions.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  // state   | meaning
  // ST_IDLE | waiting for start; results held
  // ST_RUN  | iterating, one bit per cycle; busy high

  state_t             state_q, state_d;
  logic               accept, finish;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q_bit;
  logic [2*WIDTH-1:0] acc_step;

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_q),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (step_acc),
    .q_bit    (step_q_bit)
  );

  assign acc_step = (op_q == OP_DIVU) ? {step_acc[2*WIDTH-1:1], step_q_bit} : step_acc;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          state_d = ST_RUN;
          accept  = 1'b1;
        end
      end
      ST_RUN: begin
        // Abort takes priority over completion.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == ST_RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      op_q        <= OP_MULU;
      opnd_q      <= '0;
      acc_q       <= '0;
      done        <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        // MULU keeps the multiplicand and shifts the multiplier through acc;
        // DIVU keeps the divisor and shifts the dividend through acc.
        op_q   <= op;
        opnd_q <= (op == OP_DIVU) ? operand_b : operand_a;
        acc_q  <= {{WIDTH{1'b0}}, ((op == OP_DIVU) ? operand_a : operand_b)};
        cnt_q  <= '0;
      end else if (state_q == ST_RUN && !flush) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 1'b1;
      end
      if (finish) begin
        result_lo   <= acc_step[WIDTH-1:0];
        result_hi   <= acc_step[2*WIDTH-1:WIDTH];
        div_by_zero <= (op_q == OP_DIVU) && (opnd_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic/timing model plus literal checks.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         op    = OP_MULU;
  logic         flush = 1'b0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_lo, result_hi;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit running     = 1'b1;

  mul_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Model: accepted op finishes after W cycles; results from plain arithmetic.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_lo = '0, m_hi = '0, p_lo = '0, p_hi = '0;
  logic         m_dbz = 1'b0, p_dbz = 1'b0;
  logic [2*W-1:0] prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_lo = '0; m_hi = '0; m_dbz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_lo = p_lo; m_hi = p_hi; m_dbz = p_dbz; m_done = 1'b1;
          end
        end
      end else if (start && !flush) begin
        if (op == OP_MULU) begin
          prod  = (2*W)'(operand_a) * (2*W)'(operand_b);
          p_lo  = prod[W-1:0]; p_hi = prod[2*W-1:W]; p_dbz = 1'b0;
        end else if (operand_b == '0) begin
          p_lo = '1; p_hi = operand_a; p_dbz = 1'b1;
        end else begin
          p_lo = operand_a / operand_b; p_hi = operand_a % operand_b; p_dbz = 1'b0;
        end
        m_left = W;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = x; operand_b = y;
    @(negedge clk);
    start = 1'b0; op = ~o; operand_a = 16'hA5A5; operand_b = 16'h5A5A;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  initial begin
    int n, t1, t2;
    fork
      begin : compare
        while (running) begin
          @(negedge clk);
          if (running) begin
            chk("busy", busy, (m_left > 0));
            chk("done", done, m_done);
            chk("lo", result_lo, m_lo);
            chk("hi", result_hi, m_hi);
            chk("dbz", div_by_zero, m_dbz);
          end
        end
      end
      begin : stimulus
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_lo", result_lo, 16'h0000);
        chk("rst_hi", result_hi, 16'h0000);

        issue(OP_MULU, 16'h1234, 16'h0010);
        wait_done(n);
        chk("mul1_latency", n, 16);
        chk("mul1_hi", result_hi, 16'h0001);
        chk("mul1_lo", result_lo, 16'h2340);

        issue(OP_MULU, 16'hFFFF, 16'hFFFF);
        wait_done(n);
        chk("mulmax_hi", result_hi, 16'hFFFE);
        chk("mulmax_lo", result_lo, 16'h0001);

        // Asynchronous reset in the middle of a run.
        issue(OP_MULU, 16'h1234, 16'h0010);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_lo", result_lo, 16'h0000);
        chk("arst_hi", result_hi, 16'h0000);
        chk("arst_dbz", div_by_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(OP_DIVU, 16'h0064, 16'h0007);
        wait_done(n);
        chk("div_latency", n, 16);
        chk("div_q", result_lo, 16'h000E);
        chk("div_r", result_hi, 16'h0002);
        chk("div_dbz", div_by_zero, 1'b0);

        issue(OP_DIVU, 16'h1234, 16'h0000);
        wait_done(n);
        chk("dz_latency", n, 16);
        chk("dz_q", result_lo, 16'hFFFF);
        chk("dz_r", result_hi, 16'h1234);
        chk("dz_flag", div_by_zero, 1'b1);

        // Flush mid-divide keeps the previous product.
        issue(OP_MULU, 16'h1234, 16'h0010);
        wait_done(n);
        chk("dz_cleared", div_by_zero, 1'b0);
        issue(OP_DIVU, 16'h0064, 16'h0007);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        repeat (20) @(negedge clk);
        chk("flush_hi", result_hi, 16'h0001);
        chk("flush_lo", result_lo, 16'h2340);

        // Flush beats start in IDLE.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_MULU; operand_a = 16'h0003; operand_b = 16'h0003;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", busy, 1'b0);

        // Start while busy is ignored.
        issue(OP_MULU, 16'h0003, 16'h0005);
        repeat (2) @(negedge clk);
        start = 1'b1; op = OP_DIVU; operand_a = 16'hFFFF; operand_b = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("ign_latency", n, 13);
        chk("ign_lo", result_lo, 16'h000F);
        chk("ign_hi", result_hi, 16'h0000);

        // Back-to-back: new start in the done cycle.
        issue(OP_MULU, 16'h0007, 16'h0009);
        wait_done(n);
        t1 = cyc;
        chk("b2b_first_lo", result_lo, 16'h003F);
        start = 1'b1; op = OP_DIVU; operand_a = 16'h0064; operand_b = 16'h0007;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", busy, 1'b1);
        wait_done(n);
        t2 = cyc;
        chk("b2b_period", t2 - t1, 17);
        chk("b2b_q", result_lo, 16'h000E);
        chk("b2b_r", result_hi, 16'h0002);

        repeat (3) @(negedge clk);
        running = 1'b0;
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
